// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Purpose  : Boot loader turning a UART byte stream into instruction-memory
//            word writes; holds the core in reset until the image is loaded.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_SIZE       = 512,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] C_ST_HDR_LO = 3'd0;
    localparam logic [2:0] C_ST_HDR_HI = 3'd1;
    localparam logic [2:0] C_ST_DATA   = 3'd2;
    localparam logic [2:0] C_ST_DONE   = 3'd3;
    localparam logic [2:0] C_ST_ERR    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] C_MEM_SIZE = CNT_WIDTH'(MEM_SIZE);
    localparam logic [TO_W-1:0]      C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [DATA_WIDTH-1:0] r_asm;
    logic [TO_W-1:0]       r_to_cnt;

    logic [CNT_WIDTH-1:0]  w_hdr_count;
    logic [CNT_WIDTH-1:0]  w_word_next;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_hdr_count = CNT_WIDTH'({rx_byte, r_count[7:0]});
    assign w_word_next = r_word_idx + CNT_WIDTH'(1);
    // Bytes shift in from the top so the first byte ends up in [7:0].
    assign w_word      = {rx_byte, r_asm[DATA_WIDTH-1:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= C_ST_HDR_LO;
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_to_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (r_state)
                C_ST_HDR_LO: begin
                    if (rx_valid) begin
                        r_count <= CNT_WIDTH'(rx_byte);
                        r_state <= C_ST_HDR_HI;
                    end
                end
                C_ST_HDR_HI: begin
                    if (rx_valid) begin
                        r_count    <= w_hdr_count;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_to_cnt   <= '0;
                        if (w_hdr_count == '0) begin
                            r_state   <= C_ST_DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else if (w_hdr_count > C_MEM_SIZE) begin
                            r_state  <= C_ST_ERR;
                            load_err <= 1'b1;
                        end else begin
                            r_state <= C_ST_DATA;
                        end
                    end
                end
                C_ST_DATA: begin
                    if (rx_valid) begin
                        r_to_cnt   <= '0;
                        r_asm      <= w_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            wr_en      <= 1'b1;
                            wr_data    <= w_word;
                            wr_addr    <= ADDR_WIDTH'({r_word_idx, 2'b00});
                            r_word_idx <= w_word_next;
                            // DONE state releases the core one cycle after this pulse.
                            if (w_word_next == r_count) begin
                                r_state <= C_ST_DONE;
                            end
                        end
                    end else if (r_to_cnt == C_TO_LAST) begin
                        r_state  <= C_ST_ERR;
                        load_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                C_ST_DONE: begin
                    load_done <= 1'b1;
                    cpu_reset <= 1'b0;
                end
                C_ST_ERR: begin
                    load_err  <= 1'b1;
                    cpu_reset <= 1'b1;
                end
                default: begin
                    r_state <= C_ST_HDR_LO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Purpose  : Directed self-checking bench for instr_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    int n_pass  = 0;
    int n_total = 0;

    // Every write pulse is logged here; each test indexes from its own base.
    logic [31:0] pa [32];
    logic [31:0] pd [32];
    int          np = 0;
    int          base;

    instr_loader #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .MEM_SIZE      (512),
        .CNT_WIDTH     (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (np < 32) begin
                pa[np] = wr_addr;
                pd[np] = wr_data;
            end
            np = np + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_wr_addr"},   wr_addr,        32'd0);
        chk({tag, "_wr_data"},   wr_data,        32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_err"},  32'(load_err),  32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        base  = np;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tick(2);
        chk_reset_vals("por");
        reset = 1'b0;
        base  = np;

        // Basic three-word load
        send(8'h03); send(8'h00);
        send(8'h13); send(8'h01); send(8'h01); send(8'hFF);
        send(8'h23); send(8'h26); send(8'h11); send(8'h00);
        send(8'h67); send(8'h80); send(8'h00); send(8'h00);
        chk("basic_last_wr_en",     32'(wr_en),     32'd1);
        chk("basic_pulse_cpu_rst",  32'(cpu_reset), 32'd1);
        chk("basic_pulse_done",     32'(load_done), 32'd0);
        tick(1);
        chk("basic_cpu_rst_fall",   32'(cpu_reset), 32'd0);
        chk("basic_done_rise",      32'(load_done), 32'd1);
        chk("basic_wr_en_low",      32'(wr_en),     32'd0);
        chk("basic_pulses",         32'(np - base), 32'd3);
        chk("basic_a0", pa[base],     32'h0);
        chk("basic_d0", pd[base],     32'hFF010113);
        chk("basic_a1", pa[base + 1], 32'h4);
        chk("basic_d1", pd[base + 1], 32'h00112623);
        chk("basic_a2", pa[base + 2], 32'h8);
        chk("basic_d2", pd[base + 2], 32'h00008067);
        chk("basic_err", 32'(load_err), 32'd0);

        // Empty image
        do_reset();
        chk_reset_vals("rst1");
        send(8'h00); send(8'h00);
        chk("empty_done",    32'(load_done), 32'd1);
        chk("empty_cpu_rst", 32'(cpu_reset), 32'd0);
        tick(2);
        chk("empty_pulses",  32'(np - base), 32'd0);

        // Oversize image (513 words)
        do_reset();
        send(8'h01); send(8'h02);
        chk("over_err",     32'(load_err),  32'd1);
        chk("over_cpu_rst", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 8; i++) send(8'(i + 1));
        tick(2);
        chk("over_pulses",  32'(np - base), 32'd0);
        chk("over_done",    32'(load_done), 32'd0);
        chk("over_err_hold", 32'(load_err), 32'd1);

        // Timeout: 5 data bytes of a 2-word image, then silence
        do_reset();
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        tick(15);
        chk("to_err_before", 32'(load_err), 32'd0);
        tick(1);
        chk("to_err",        32'(load_err),  32'd1);
        chk("to_cpu_rst",    32'(cpu_reset), 32'd1);
        chk("to_pulses",     32'(np - base), 32'd1);
        chk("to_d0",         pd[base],       32'h44332211);
        chk("to_done",       32'(load_done), 32'd0);

        // Back-to-back bytes, then traffic after DONE
        do_reset();
        send(8'h01); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        tick(1);
        send(8'h99); send(8'h98); send(8'h97); send(8'h96); send(8'h95);
        tick(2);
        chk("b2b_pulses",  32'(np - base), 32'd1);
        chk("b2b_a0",      pa[base],       32'h0);
        chk("b2b_d0",      pd[base],       32'hEFBEADDE);
        chk("b2b_addr",    wr_addr,        32'h0);
        chk("b2b_data",    wr_data,        32'hEFBEADDE);
        chk("b2b_done",    32'(load_done), 32'd1);

        // Reset in the middle of a 4-word image
        do_reset();
        send(8'h04); send(8'h00);
        for (int i = 0; i < 6; i++) send(8'(i + 1));
        chk("mid_pulses", 32'(np - base), 32'd1);
        chk("mid_d0",     pd[base],       32'h04030201);
        reset = 1'b1;
        tick(1);
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        base  = np;
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        tick(1);
        chk("mid_new_pulses", 32'(np - base), 32'd1);
        chk("mid_new_a0",     pa[base],       32'h0);
        chk("mid_new_d0",     pd[base],       32'hDDCCBBAA);
        chk("mid_new_done",   32'(load_done), 32'd1);
        chk("mid_new_cpu",    32'(cpu_reset), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
